// File: rtl/instr_rom_arbiter.sv
// Arbitrates the shared instruction ROM between CPU fetch and the debug read port.
// The CPU has priority; a starvation counter bounds how long debug can be held off.
module instr_rom_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_stall,
    output logic              cpu_valid,
    output logic [DATA_W-1:0] cpu_data,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic {
        D_IDLE = 1'b0,
        D_ACK  = 1'b1
    } dbg_state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    dbg_state_t state, state_next;
    logic [3:0] starve_cnt, starve_next;
    logic       dbg_pending;
    logic       grant_dbg;
    logic       grant_cpu;

    // Arbitration, ROM address mux, debug handshake and starvation tracking.
    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        dbg_pending = dbg_req && (state == D_IDLE);
        grant_dbg   = dbg_pending && (!cpu_req || (starve_cnt == STARVE_LIM));
        grant_cpu   = cpu_req && !grant_dbg;
        cpu_stall   = cpu_req && grant_dbg;
        rom_addr    = grant_dbg ? dbg_addr : cpu_addr;

        case (state)
            D_IDLE: if (grant_dbg) state_next = D_ACK;
            D_ACK:  if (!dbg_req)  state_next = D_IDLE;
            default: state_next = D_IDLE;
        endcase

        if (grant_dbg || !dbg_pending) begin
            starve_next = 4'd0;
        end else if (starve_cnt < STARVE_LIM) begin
            starve_next = starve_cnt + 4'd1;
        end
    end

    // The ack is the state flop itself, so it drops on the same edge a reset lands.
    assign dbg_ack = (state == D_ACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= D_IDLE;
            starve_cnt <= 4'd0;
            cpu_valid  <= 1'b0;
            cpu_data   <= '0;
            dbg_data   <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            cpu_valid  <= grant_cpu;
            if (grant_cpu) cpu_data <= rom_data;
            if (grant_dbg) dbg_data <= rom_data;
        end
    end

endmodule

// File: tb/tb_instr_rom_arbiter.sv
// Directed test of instr_rom_arbiter against a behavioural ROM, with a queue
// scoreboard that checks returned words whenever cpu_valid or a new dbg_ack appears.
module tb_instr_rom_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [9:0]  cpu_addr;
    logic        cpu_stall;
    logic        cpu_valid;
    logic [31:0] cpu_data;
    logic        dbg_req;
    logic [9:0]  dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_data;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;

    logic [31:0] rom [0:1023];
    logic [31:0] cpu_q[$];
    logic [31:0] dbg_q[$];
    int          tests = 0;
    int          fails = 0;

    instr_rom_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_stall(cpu_stall),
        .cpu_valid(cpu_valid), .cpu_data(cpu_data),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each word is 0xC0DE0000 | address, except the two hand-picked entries.
    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'hC0DE_0000 | i;
        rom[3]      = 32'h2008_0005;
        rom[10'h3FF] = 32'hDEAD_BEEF;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change at the falling edge; combinational outputs are checked 1ns later.
    task automatic applyStimulus(input logic r, input logic creq, input logic [9:0] caddr,
                                 input logic dreq, input logic [9:0] daddr);
        @(negedge clk);
        rst      = r;
        cpu_req  = creq;
        cpu_addr = caddr;
        dbg_req  = dreq;
        dbg_addr = daddr;
        #1;
    endtask

    // Scoreboard monitor: registered outputs are stable at the falling edge.
    logic        prev_ack = 1'b0;
    logic [31:0] held_dbg = '0;
    always @(negedge clk) begin
        if (cpu_valid === 1'b1) begin
            if (cpu_q.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL cpu_unexpected_valid: got cpu_valid=1 data 0x%08h, expected no response", cpu_data);
            end else begin
                checkOutput("cpu_data", cpu_data, cpu_q.pop_front());
            end
        end
        if (dbg_ack === 1'b1 && prev_ack !== 1'b1) begin
            if (dbg_q.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL dbg_unexpected_ack: got dbg_ack=1 data 0x%08h, expected no response", dbg_data);
            end else begin
                held_dbg = dbg_q.pop_front();
                checkOutput("dbg_data", dbg_data, held_dbg);
            end
        end else if (dbg_ack === 1'b1) begin
            checkOutput("dbg_data_hold", dbg_data, held_dbg);
        end
        prev_ack = dbg_ack;
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; cpu_req = 1'b1; cpu_addr = 10'h005; dbg_req = 1'b1; dbg_addr = 10'h006;

        // Reset held for two cycles with both requesters active: nothing captured.
        applyStimulus(1, 1, 10'h005, 1, 10'h006);
        applyStimulus(1, 1, 10'h005, 1, 10'h006);
        applyStimulus(0, 0, 10'h000, 0, 10'h000);
        checkOutput("rst_cpu_valid", cpu_valid, 0);
        checkOutput("rst_dbg_ack",   dbg_ack,   0);
        checkOutput("rst_cpu_data",  cpu_data,  0);
        checkOutput("rst_dbg_data",  dbg_data,  0);
        checkOutput("idle_stall",    cpu_stall, 0);

        // CPU only, back to back, including both address extremes.
        applyStimulus(0, 1, 10'h003, 0, 10'h000);
        checkOutput("cpu_rom_addr_3", rom_addr, 10'h003);
        checkOutput("cpu_stall_a", cpu_stall, 0);
        cpu_q.push_back(32'h2008_0005);
        applyStimulus(0, 1, 10'h000, 0, 10'h000);
        checkOutput("cpu_rom_addr_0", rom_addr, 10'h000);
        checkOutput("cpu_valid_b2b1", cpu_valid, 1);
        cpu_q.push_back(32'hC0DE_0000);
        applyStimulus(0, 1, 10'h3FF, 0, 10'h000);
        checkOutput("cpu_rom_addr_3ff", rom_addr, 10'h3FF);
        checkOutput("cpu_valid_b2b2", cpu_valid, 1);
        checkOutput("cpu_stall_b", cpu_stall, 0);
        cpu_q.push_back(32'hDEAD_BEEF);
        applyStimulus(0, 0, 10'h000, 0, 10'h000);
        checkOutput("cpu_valid_last", cpu_valid, 1);
        applyStimulus(0, 0, 10'h000, 0, 10'h000);
        checkOutput("cpu_valid_drop", cpu_valid, 0);

        // Debug only: ack one cycle after grant, held while dbg_req stays high.
        applyStimulus(0, 0, 10'h055, 1, 10'h3FF);
        checkOutput("dbg_rom_addr", rom_addr, 10'h3FF);
        checkOutput("dbg_ack_pre", dbg_ack, 0);
        dbg_q.push_back(32'hDEAD_BEEF);
        applyStimulus(0, 0, 10'h055, 1, 10'h3FF);
        checkOutput("dbg_ack_rise", dbg_ack, 1);
        checkOutput("idle_rom_addr_cpu", rom_addr, 10'h055);
        applyStimulus(0, 0, 10'h055, 1, 10'h3FF);
        checkOutput("dbg_ack_held", dbg_ack, 1);
        applyStimulus(0, 0, 10'h055, 0, 10'h3FF);
        checkOutput("dbg_ack_until_seen_low", dbg_ack, 1);
        applyStimulus(0, 0, 10'h055, 0, 10'h3FF);
        checkOutput("dbg_ack_fall", dbg_ack, 0);

        // Both requests rise together: CPU wins cycles 0-3, debug at cycle 4.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 10'h100 + 10'(k), 1, 10'h200);
            checkOutput("cont_stall_cpu_win", cpu_stall, 0);
            checkOutput("cont_rom_addr_cpu", rom_addr, 10'h100 + 10'(k));
            cpu_q.push_back(32'hC0DE_0100 + k);
        end
        applyStimulus(0, 1, 10'h104, 1, 10'h200);
        checkOutput("cont_stall_dbg_win", cpu_stall, 1);
        checkOutput("cont_rom_addr_dbg", rom_addr, 10'h200);
        dbg_q.push_back(32'hC0DE_0200);
        applyStimulus(0, 1, 10'h104, 1, 10'h200);
        checkOutput("cont_cpu_valid_gap", cpu_valid, 0);
        checkOutput("cont_dbg_ack", dbg_ack, 1);
        checkOutput("cont_stall_resume", cpu_stall, 0);
        checkOutput("cont_rom_addr_resume", rom_addr, 10'h104);
        cpu_q.push_back(32'hC0DE_0104);
        applyStimulus(0, 0, 10'h000, 0, 10'h200);
        checkOutput("cont_cpu_valid_back", cpu_valid, 1);
        applyStimulus(0, 0, 10'h000, 0, 10'h000);
        checkOutput("cont_dbg_ack_fall", dbg_ack, 0);

        // Reset in the middle of a handshake, with a CPU request in the reset cycle.
        applyStimulus(0, 0, 10'h000, 1, 10'h3FF);
        dbg_q.push_back(32'hDEAD_BEEF);
        applyStimulus(0, 0, 10'h000, 1, 10'h3FF);
        checkOutput("mid_dbg_ack", dbg_ack, 1);
        applyStimulus(1, 1, 10'h003, 1, 10'h3FF);
        applyStimulus(0, 0, 10'h000, 1, 10'h3FF);
        checkOutput("mid_rst_dbg_ack", dbg_ack, 0);
        checkOutput("mid_rst_dbg_data", dbg_data, 0);
        checkOutput("mid_rst_cpu_valid", cpu_valid, 0);
        checkOutput("mid_rst_cpu_data", cpu_data, 0);
        checkOutput("mid_regrant_addr", rom_addr, 10'h3FF);
        dbg_q.push_back(32'hDEAD_BEEF);
        applyStimulus(0, 0, 10'h000, 1, 10'h3FF);
        checkOutput("mid_regrant_ack", dbg_ack, 1);
        applyStimulus(0, 0, 10'h000, 0, 10'h000);
        applyStimulus(0, 0, 10'h000, 0, 10'h000);
        checkOutput("mid_final_ack", dbg_ack, 0);

        applyStimulus(0, 0, 10'h000, 0, 10'h000);
        checkOutput("cpu_q_drained", cpu_q.size(), 0);
        checkOutput("dbg_q_drained", dbg_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
